// File: rtl/loop_pkg.sv
// Shared types and limits for the nested-loop index generator.
package loop_pkg;

    localparam int LOOP_MAX_LEVELS = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } loop_state_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } loop_dir_e;

endpackage

// File: rtl/loop_nest_level.sv
// One level of the loop nest: captured bounds/direction and the running index.
// Optional stepping by a captured stride under LOOP_NEST_STRIDE_EN.
module loop_nest_level
    import loop_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         advance,
    input  logic         carry_in,
    input  logic [W-1:0] ini,
    input  logic [W-1:0] fin,
    input  logic         dir,
`ifdef LOOP_NEST_STRIDE_EN
    input  logic [W-1:0] stride,
`endif
    output logic [W-1:0] data,
    output logic         at_final,
    output logic         carry_out
);

    logic [W-1:0] r_ini;
    logic [W-1:0] r_fin;
    loop_dir_e    r_dir;
    logic [W-1:0] r_data;
    logic [W-1:0] w_inc;
    logic [W-1:0] w_step;

`ifdef LOOP_NEST_STRIDE_EN
    logic [W-1:0] r_stride;

    // A zero stride would never reach fin, so it is captured as one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stride <= '0;
        end else if (load) begin
            r_stride <= (stride == '0) ? W'(1) : stride;
        end
    end

    assign w_inc    = r_stride;
    assign at_final = (r_dir == UP) ? ((r_fin - r_data) < r_stride)
                                    : ((r_data - r_fin) < r_stride);

    always_ff @(posedge clk) begin
        if (rst_n && load) begin
            assert (dir ? (ini >= fin) : (ini <= fin));
        end
    end
`else
    assign w_inc    = W'(1);
    assign at_final = (r_data == r_fin);
`endif

    assign w_step    = (r_dir == UP) ? (r_data + w_inc) : (r_data - w_inc);
    assign carry_out = carry_in & at_final;
    assign data      = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ini  <= '0;
            r_fin  <= '0;
            r_dir  <= UP;
            r_data <= '0;
        end else if (load) begin
            r_ini  <= ini;
            r_fin  <= fin;
            r_dir  <= loop_dir_e'(dir);
            r_data <= ini;
        end else if (advance) begin
            r_data <= at_final ? r_ini : w_step;
        end
    end

endmodule

// File: rtl/loop_nest.sv
// Nested-loop index generator: IDLE/RUN control plus the inter-level carry chain.
// Optional per-level stride input under LOOP_NEST_STRIDE_EN.
module loop_nest
    import loop_pkg::*;
#(
    parameter int W      = 32,
    parameter int LEVELS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LEVELS*W-1:0] cfg_ini,
    input  logic [LEVELS*W-1:0] cfg_fin,
    input  logic [LEVELS-1:0]   cfg_dir,
`ifdef LOOP_NEST_STRIDE_EN
    input  logic [LEVELS*W-1:0] cfg_stride,
`endif
    input  logic                start,
    input  logic                en,
    output logic                busy,
    output logic                valid,
    output logic [LEVELS*W-1:0] data,
    output logic [LEVELS-1:0]   last,
    output logic                done
);

    loop_state_e       r_state;
    loop_state_e       w_state_next;
    logic              w_load;
    logic              w_step;
    logic [LEVELS:0]   w_carry;
    logic [LEVELS-1:0] w_at_final;

    assign w_load     = (r_state == IDLE) & start;
    assign w_step     = (r_state == RUN) & en;
    assign w_carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < LEVELS; gi++) begin : g_level
            loop_nest_level #(.W(W)) u_level (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (w_load),
                .advance   (w_step & w_carry[gi]),
                .carry_in  (w_carry[gi]),
                .ini       (cfg_ini[gi*W +: W]),
                .fin       (cfg_fin[gi*W +: W]),
                .dir       (cfg_dir[gi]),
`ifdef LOOP_NEST_STRIDE_EN
                .stride    (cfg_stride[gi*W +: W]),
`endif
                .data      (data[gi*W +: W]),
                .at_final  (w_at_final[gi]),
                .carry_out (w_carry[gi+1])
            );

            assign last[gi] = w_step & w_carry[gi] & w_at_final[gi];
        end
    endgenerate

    assign busy  = (r_state == RUN);
    assign valid = busy;
    assign done  = last[LEVELS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Leaving RUN on done also covers a start in the same cycle: it is not seen in RUN.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (done)  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

endmodule
